// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [31:0] TXDATA_OFF = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;

  localparam int unsigned ST_FULL   = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_ACTIVE = 2;
  localparam int unsigned ST_OVF    = 3;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO. A push into a full FIFO is accepted when a pop happens in the same cycle.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO and combinational status read.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int unsigned   BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          ovf;

  logic          sel_data;
  logic          sel_status;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          active;
  logic          baud_done;
  logic [7:0]    pop_data;
  logic          unused_wd;

  assign sel_data   = a == BASE_ADDR + TXDATA_OFF;
  assign sel_status = a == BASE_ADDR + STATUS_OFF;
  assign push       = we && sel_data;
  assign baud_done  = baud == BaudLast;
  assign active     = state != StIdle;
  // Pop either from idle or on the final stop cycle so frames run back to back.
  assign pop        = !empty && (state == StIdle || (state == StStop && baud_done));
  assign unused_wd  = ^wd[31:8];

  fifo_sync #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(wd[7:0]),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    rd = '0;
    if (sel_status) begin
      rd[ST_FULL]   = full;
      rd[ST_EMPTY]  = empty;
      rd[ST_ACTIVE] = active;
      rd[ST_OVF]    = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (push && full && !pop) begin
      ovf <= 1'b1;
    end else if (we && sel_status && wd[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (pop) begin
      parity <= ^pop_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          baud    <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          if (pop) begin
            shift <= pop_data;
            state <= StStart;
            tx    <= 1'b0;
          end
        end
        StStart: begin
          if (baud_done) begin
            baud  <= '0;
            state <= StData;
            tx    <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        StData: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= StParity;
              tx    <= parity;
`else
              state <= StStop;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (baud_done) begin
            baud  <= '0;
            state <= StStop;
            tx    <= 1'b1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif
        StStop: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            if (pop) begin
              shift <= pop_data;
              state <= StStart;
              tx    <= 1'b0;
            end else begin
              state <= StIdle;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= StIdle;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
